// File: rtl/dcf77_frame_decoder_if.sv
// Decoded-time bus from the DCF77 frame decoder to the display loop register,
// together with the decoder's status strobes.
interface dcf77_frame_decoder_if;
  logic [47:0] parallelInput;
  logic        flag_load;
  logic        frame_ok;
  logic        frame_err;
  logic        sec_pulse;

  modport master (output parallelInput, flag_load, frame_ok, frame_err, sec_pulse);
  modport slave  (input  parallelInput, flag_load, frame_ok, frame_err, sec_pulse);
endinterface

// File: rtl/dcf77_frame_decoder.sv
// DCF77 minute-frame decoder: times pulses/gaps in ms, assembles the 59-bit frame,
// validates it at each minute marker and presents the BCD time/date word.
module dcf77_frame_decoder #(
  parameter int TICKS_PER_MS = 50000
) (
  input  logic                  qzt_clk,
  input  logic                  rst_n,
  input  logic                  dcf_in,
  dcf77_frame_decoder_if.master dout
);
  localparam int              PW      = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(TICKS_PER_MS - 1);
  localparam logic [10:0]     DUR_MAX = 11'd2047;
  localparam logic [10:0]     MARK_MS = 11'd1500;
  localparam logic [47:0]     BLANK   = 48'hAAAA_AAAA_AAAA;

  typedef enum logic [1:0] {HUNT, PULSE, GAP} state_t;

  state_t        state_q, state_n;
  logic          dcf_p0, dcf_s, dcf_d;
  logic [PW-1:0] pre_cnt;
  logic [10:0]   dur_ms;
  logic [5:0]    bit_cnt;
  logic [58:0]   frame;
  logic          bad, synced;
  logic          rise, fall, ms_tick, bit_is_0, bit_is_1;
  logic          wr_bit, set_bad, clr_frame, set_sync, lost, do_eval, sec_hit;
  logic [47:0]   cand;
  logic          frame_valid;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == DUR_MAX) ? v : v + 11'd1;
  endfunction

  function automatic logic bcd_valid(input logic [47:0] w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 12; i++)
      if (w[i*4 +: 4] > 4'd9) ok = 1'b0;
    if (w[15:8] > 8'h59) ok = 1'b0;
    if (w[23:16] > 8'h23) ok = 1'b0;
    if (w[31:24] == 8'h00 || w[31:24] > 8'h31) ok = 1'b0;
    if (w[39:32] == 8'h00 || w[39:32] > 8'h12) ok = 1'b0;
    return ok;
  endfunction

  assign rise     = dcf_s & ~dcf_d;
  assign fall     = ~dcf_s & dcf_d;
  assign ms_tick  = (pre_cnt == PRE_MAX);
  assign bit_is_0 = (dur_ms >= 11'd40)  && (dur_ms <= 11'd129);
  assign bit_is_1 = (dur_ms >= 11'd130) && (dur_ms <= 11'd250);

  assign cand = {frame[57:50], 3'b000, frame[49:45], 2'b00, frame[41:36],
                 2'b00, frame[34:29], 1'b0, frame[27:21], 8'h00};

  assign frame_valid = (bit_cnt == 6'd59) && !bad && !frame[0] && frame[20] &&
                       !(^frame[28:21]) && !(^frame[35:29]) && !(^frame[58:36]) &&
                       bcd_valid(cand);

  always_comb begin
    state_n   = state_q;
    wr_bit    = 1'b0;
    set_bad   = 1'b0;
    clr_frame = 1'b0;
    set_sync  = 1'b0;
    lost      = 1'b0;
    do_eval   = 1'b0;
    sec_hit   = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (rise) begin
          state_n = PULSE;
          if (dur_ms >= MARK_MS) begin
            clr_frame = 1'b1;
            set_sync  = 1'b1;
          end
        end
      end
      PULSE: begin
        if (dur_ms == DUR_MAX) begin
          state_n = HUNT;
          lost    = 1'b1;
        end else if (fall) begin
          state_n = GAP;
          if (!bit_is_0 && !bit_is_1) set_bad = 1'b1;
          else if (bit_cnt == 6'd59)  set_bad = 1'b1;
          else                        wr_bit  = 1'b1;
        end
      end
      GAP: begin
        if (dur_ms == DUR_MAX) begin
          state_n = HUNT;
          lost    = 1'b1;
        end else if (rise) begin
          state_n = PULSE;
          sec_hit = 1'b1;
          if (dur_ms >= MARK_MS) begin
            clr_frame = 1'b1;
            // An unsynchronised marker only establishes sync; it never loads.
            if (synced) do_eval  = 1'b1;
            else        set_sync = 1'b1;
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      dcf_p0  <= 1'b0;
      dcf_s   <= 1'b0;
      dcf_d   <= 1'b0;
      pre_cnt <= '0;
      dur_ms  <= '0;
      state_q <= HUNT;
      bit_cnt <= '0;
      frame   <= '0;
      bad     <= 1'b0;
      synced  <= 1'b0;
    end else begin
      dcf_p0  <= dcf_in;
      dcf_s   <= dcf_p0;
      dcf_d   <= dcf_s;
      pre_cnt <= ms_tick ? '0 : pre_cnt + 1'b1;
      if (rise || fall)  dur_ms <= '0;
      else if (ms_tick)  dur_ms <= sat_inc(dur_ms);
      state_q <= state_n;
      if (clr_frame) begin
        frame   <= '0;
        bit_cnt <= '0;
        bad     <= 1'b0;
      end else begin
        if (wr_bit) begin
          frame[bit_cnt] <= bit_is_1;
          bit_cnt        <= bit_cnt + 6'd1;
        end
        if (set_bad) bad <= 1'b1;
      end
      if (lost)          synced <= 1'b0;
      else if (set_sync) synced <= 1'b1;
    end
  end

  // Output stage: strobes and the loaded word are registered one cycle after the decision.
  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      dout.parallelInput <= BLANK;
      dout.flag_load     <= 1'b0;
      dout.frame_ok      <= 1'b0;
      dout.frame_err     <= 1'b0;
      dout.sec_pulse     <= 1'b0;
    end else begin
      dout.flag_load <= do_eval & frame_valid;
      dout.frame_err <= do_eval & ~frame_valid;
      dout.sec_pulse <= sec_hit;
      if (do_eval && frame_valid) dout.parallelInput <= cand;
      if (lost)         dout.frame_ok <= 1'b0;
      else if (do_eval) dout.frame_ok <= frame_valid;
    end
  end
endmodule

// File: tb/tb_dcf77_frame_decoder.sv
// Bench for dcf77_frame_decoder: randomized DCF77 pulse trains against a
// second-level reference model, with a scoreboard monitor on the output strobes.
module tb_dcf77_frame_decoder;
  // One tick per ms keeps a full minute frame to a few thousand cycles.
  localparam int TPM = 1;

  typedef struct packed {
    logic        is_load;
    logic [47:0] word;
  } exp_t;

  logic clk, rst_n, dcf_in;
  dcf77_frame_decoder_if dout_if();

  dcf77_frame_decoder #(.TICKS_PER_MS(TPM)) dut (
    .qzt_clk(clk),
    .rst_n  (rst_n),
    .dcf_in (dcf_in),
    .dout   (dout_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_err    = 0;
  exp_t        sb_q[$];
  logic [47:0] cur_word = 48'hAAAA_AAAA_AAAA;
  bit          mon_en   = 1'b0;
  int          sec_seen = 0;

  // Reference model state: 0 = hunting, 1 = running unsynchronised, 2 = synchronised.
  int mode    = 0;
  bit fb[$];
  bit mbad    = 1'b0;
  bit m_ok    = 1'b0;
  int exp_sec = 0;

  task automatic check(input string nm, input logic [47:0] act, input logic [47:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int fld(input int lo, input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(fb[lo+i]) << i;
    return s;
  endfunction

  function automatic int par(input int lo, input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(fb[lo+i]);
    return s % 2;
  endfunction

  task automatic model_marker();
    bit v;
    int miu, mit, hu, ht, du, dt, mou, mot, yu, yt;
    exp_t e;
    v = (fb.size() == 59) && !mbad;
    e.word = cur_word;
    if (v) begin
      miu = fld(21, 4); mit = fld(25, 3);
      hu  = fld(29, 4); ht  = fld(33, 2);
      du  = fld(36, 4); dt  = fld(40, 2);
      mou = fld(45, 4); mot = fld(49, 1);
      yu  = fld(50, 4); yt  = fld(54, 4);
      v = (fb[0] == 1'b0) && (fb[20] == 1'b1) &&
          par(21, 8) == 0 && par(29, 7) == 0 && par(36, 23) == 0 &&
          miu <= 9 && mit * 10 + miu <= 59 &&
          hu <= 9 && ht * 10 + hu <= 23 &&
          du <= 9 && dt * 10 + du >= 1 && dt * 10 + du <= 31 &&
          mou <= 9 && mot * 10 + mou >= 1 && mot * 10 + mou <= 12 &&
          yu <= 9 && yt <= 9;
      if (v) e.word = {4'(yt), 4'(yu), 4'(mot), 4'(mou), 4'(dt), 4'(du),
                       4'(ht), 4'(hu), 4'(mit), 4'(miu), 8'h00};
    end
    e.is_load = v;
    m_ok = v;
    sb_q.push_back(e);
  endtask

  task automatic model_rise(input int gap);
    if (gap >= 2048) begin
      mode = 0;
      m_ok = 1'b0;
    end
    if (mode == 0) begin
      if (gap >= 1500) begin
        mode = 2;
        fb.delete();
        mbad = 1'b0;
      end else mode = 1;
    end else begin
      exp_sec++;
      if (gap >= 1500) begin
        if (mode == 2) model_marker();
        else           mode = 2;
        fb.delete();
        mbad = 1'b0;
      end
    end
  endtask

  task automatic model_fall(input int w);
    if (mode != 0) begin
      if (w >= 40 && w <= 250) begin
        if (fb.size() == 59) mbad = 1'b1;
        else                 fb.push_back(w >= 130);
      end else mbad = 1'b1;
    end
  endtask

  task automatic wait_ms(input int ms);
    repeat (ms * TPM) @(posedge clk);
    #1;
  endtask

  task automatic send_pulse(input int gap, input int width);
    wait_ms(gap);
    if (gap >= 2048) check("frame_ok_after_loss", 48'(dout_if.frame_ok), 48'(0));
    dcf_in = 1'b1;
    model_rise(gap);
    wait_ms(width);
    check("frame_ok", 48'(dout_if.frame_ok), 48'(m_ok));
    dcf_in = 1'b0;
    model_fall(width);
  endtask

  function automatic logic [58:0] build_frame(input int mi, input int hr, input int dy,
                                              input int wd, input int mo, input int yr);
    logic [58:0] f;
    f = {27'd0, 32'($urandom)};
    f[0]     = 1'b0;
    f[20]    = 1'b1;
    f[24:21] = 4'(mi % 10);
    f[27:25] = 3'(mi / 10);
    f[28]    = ^f[27:21];
    f[32:29] = 4'(hr % 10);
    f[34:33] = 2'(hr / 10);
    f[35]    = ^f[34:29];
    f[39:36] = 4'(dy % 10);
    f[41:40] = 2'(dy / 10);
    f[44:42] = 3'(wd);
    f[48:45] = 4'(mo % 10);
    f[49]    = 1'(mo / 10);
    f[53:50] = 4'(yr % 10);
    f[57:54] = 4'(yr / 10);
    f[58]    = ^f[57:36];
    return f;
  endfunction

  function automatic logic [58:0] rand_frame();
    return build_frame($urandom_range(0, 59), $urandom_range(0, 23), $urandom_range(1, 31),
                       $urandom_range(1, 7), $urandom_range(1, 12), $urandom_range(0, 99));
  endfunction

  task automatic send_frame(input logic [58:0] f, input int n, input int glitch_at,
                            input int first_gap);
    int gap, w;
    bit b;
    for (int i = 0; i < n; i++) begin
      if (i == 0) gap = (first_gap > 0) ? first_gap : $urandom_range(1520, 1600);
      else        gap = $urandom_range(2, 5);
      b = (i < 59) ? f[i] : 1'($urandom);
      if (i == glitch_at) w = 20;
      else if (b)         w = $urandom_range(133, 150);
      else                w = $urandom_range(43, 60);
      send_pulse(gap, w);
    end
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (dout_if.sec_pulse) sec_seen++;
        if (dout_if.flag_load || dout_if.frame_err) begin
          if (sb_q.size() == 0) begin
            check("unexpected_strobe", {46'd0, dout_if.flag_load, dout_if.frame_err}, 48'd0);
          end else begin
            e = sb_q.pop_front();
            check("strobe_kind", {46'd0, dout_if.flag_load, dout_if.frame_err},
                  {46'd0, e.is_load, !e.is_load});
            check("word_at_strobe", dout_if.parallelInput, e.word);
            check("frame_ok_at_strobe", 48'(dout_if.frame_ok), 48'(e.is_load));
            cur_word = e.word;
          end
        end else begin
          check("word_stable", dout_if.parallelInput, cur_word);
        end
      end
    end
  end

  initial begin
    logic [58:0] fa, fp, fr;
    rst_n  = 1'b0;
    dcf_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_word",      dout_if.parallelInput, 48'hAAAA_AAAA_AAAA);
    check("rst_flag_load", 48'(dout_if.flag_load), 48'(0));
    check("rst_frame_ok",  48'(dout_if.frame_ok),  48'(0));
    check("rst_frame_err", 48'(dout_if.frame_err), 48'(0));
    check("rst_sec_pulse", 48'(dout_if.sec_pulse), 48'(0));
    rst_n  = 1'b1;
    mon_en = 1'b1;

    fa = build_frame(37, 14, 21, 5, 6, 24);
    fp = fa;
    fp[35] = ~fp[35];

    send_frame(fa, 59, -1, 1600);          // first marker only resynchronises
    send_frame(fp, 59, -1, 0);             // marker loads 14:37 21.06.24
    send_frame(rand_frame(), 59, 10, 0);   // marker rejects parity error
    send_frame(rand_frame(), 59, -1, 0);   // marker rejects glitch frame
    send_frame(rand_frame(), 20, -1, 0);   // marker loads; then partial frame
    send_frame(rand_frame(), 59, -1, 2100);// signal loss, rise resynchronises
    fr = rand_frame();
    send_frame(fr, 58, -1, 0);             // marker loads frame after loss
    send_frame(rand_frame(), 60, -1, 0);   // marker rejects short frame
    send_pulse($urandom_range(1520, 1600), 50); // marker rejects overrun frame
    wait_ms(20);

    check("scoreboard_drained", 48'(sb_q.size()), 48'(0));
    check("sec_pulse_count",    48'(sec_seen),    48'(exp_sec));

    // Asynchronous reset away from any clock edge
    mon_en = 1'b0;
    dcf_in = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_word",      dout_if.parallelInput, 48'hAAAA_AAAA_AAAA);
    check("async_rst_frame_ok",  48'(dout_if.frame_ok),  48'(0));
    check("async_rst_flag_load", 48'(dout_if.flag_load), 48'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/dcf77_frame_decoder.md
# dcf77_frame_decoder

Receives the demodulated DCF77 pulse train and measures pulse widths and gaps in milliseconds. It assembles the 59-bit minute frame, locates the minute marker and checks the frame's fixed bits, parity and BCD ranges. On each valid frame it presents the decoded time/date as a 48-bit BCD word with a one-cycle `flag_load` strobe. It sits directly upstream of the 80-bit display loop register and drives that register's `parallelInput` and `flag_load` ports.

## Interface
- `TICKS_PER_MS`, 50000, `qzt_clk` cycles per millisecond. Use 4 in simulation.
- `qzt_clk` in 1: single system clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `dcf_in` in 1: raw receiver output, asynchronous; high = carrier reduced (pulse).
- `parallelInput` out 48: BCD word, packed as follows:
  - [7:0] seconds
  - [15:8] minutes
  - [23:16] hours
  - [31:24] day
  - [39:32] month
  - [47:40] year
- `flag_load` out 1: one-cycle strobe when `parallelInput` is updated.
- `frame_ok` out 1: high while the most recent frame was valid and sync is held.
- `frame_err` out 1: one-cycle strobe when a frame is rejected at a minute marker.
- `sec_pulse` out 1: one-cycle strobe on every accepted pulse rising edge.

## Operation
- **Input sync:** `dcf_in` passes through two flops to give `dcf_s`; `dcf_d` is `dcf_s` delayed one cycle. Rise = `dcf_s & ~dcf_d`; fall = `~dcf_s & dcf_d`.
- **Prescaler:** free-running counter 0..TICKS_PER_MS-1 from reset. `ms_tick` asserts at the wrap.
- **Duration counter:** 11-bit `dur_ms` increments on `ms_tick` and saturates at 2047. It clears on every rise and every fall.
- **States:**
  - `HUNT`: no marker seen since reset or signal loss.
  - `PULSE`: `dcf_s` high, measuring pulse width.
  - `GAP`: `dcf_s` low, measuring gap.
- **Fall in `PULSE` → `GAP`:** classify `dur_ms`.
  - 40..129: bit = 0.
  - 130..250: bit = 1.
  - Any other width: glitch; set the sticky `bad` flag and shift nothing.
  - Valid bits are written to `frame[bit_cnt]`, then `bit_cnt` increments.
  - If `bit_cnt` is already 59, set `bad` instead (overrun); `bit_cnt` does not exceed 59.
- **Rise in `GAP` → `PULSE`:** assert `sec_pulse`.
  - If `dur_ms` ≥ 1500, this is a minute marker. Evaluate the frame, then clear `bit_cnt`, `bad` and `frame`.
- **Frame valid when all of:**
  - `bit_cnt` = 59 and `!bad`.
  - frame[0] = 0 and frame[20] = 1.
  - Even parity holds over [28:21], [35:29] and [58:36].
  - Ranges: minutes ≤ 0x59, hours ≤ 0x23, day 0x01..0x31, month 0x01..0x12, every nibble ≤ 9.
- **Valid frame:** update `parallelInput` and pulse `flag_load`.
  - {year, month, day, hours, minutes, seconds} = {frame[57:50], 3'b0, frame[49:45], 2'b0, frame[41:36], 2'b0, frame[34:29], 1'b0, frame[27:21], 8'h00}.
  - Set `frame_ok`.
- **Invalid frame:** pulse `frame_err`, clear `frame_ok`; `parallelInput` is unchanged.
- **`HUNT`:**
  - Ignore pulse classification.
  - A rise after a gap ≥ 1500 ms enters `PULSE` with `bit_cnt` = 0, and produces no `flag_load` and no `frame_err`.
  - A rise after a shorter gap enters `PULSE` but stays unsynchronised (internal `synced` = 0); the next marker still takes the no-load path.
- **Signal loss:** `dur_ms` reaching 2047 in `GAP` or `PULSE` → `HUNT`, clear `frame_ok`, clear `synced`.
- **Reset values:**
  - `parallelInput` = 48'hAAAA_AAAA_AAAA (blank digits).
  - `flag_load`, `frame_ok`, `frame_err`, `sec_pulse` = 0.
  - State `HUNT`; `bit_cnt`, `dur_ms`, `bad`, `frame` = 0; sync flops = 0.

## Timing
- **Latency:** `dcf_in` rising at clock edge N produces an edge detect in cycle N+3. `sec_pulse`, `flag_load`, `frame_err` and the `parallelInput` update are registered and appear in cycle N+4. Each is exactly one cycle wide.
- **Coherence:** `parallelInput` changes only in the cycle `flag_load` is high and is stable at all other times; the downstream register may sample it in that cycle.
- **Resolution:** ±1 ms quantisation on every width; thresholds are inclusive as listed.
- **Asynchronous reset:** `rst_n` low at any time, including mid-frame or mid-strobe, forces reset values immediately. The first marker after release only resynchronises and does not load.

## Test plan
1. **Reset:** `rst_n` low, then high, with `dcf_in` = 0 → `parallelInput` = 48'hAAAAAAAAAAAA; all strobes 0; `frame_ok` = 0.
2. **Valid frames:** marker, then two full frames encoding 14:37 21.06.24 → first marker gives no load. At the next marker `parallelInput` = 48'h240621143700, `flag_load` is high for exactly 1 cycle at N+4, and `frame_ok` = 1. `sec_pulse` fires 59 times per frame.
3. **Parity error:** same frame with bit 35 flipped → `frame_err` strobes once, no `flag_load`, `parallelInput` keeps its previous value, `frame_ok` = 0.
4. **Glitch:** a 20 ms pulse at bit 10 → the marker produces `frame_err`. A following clean frame loads normally.
5. **Short frame:** frame with only 58 pulses → `bit_cnt` = 58 at marker, `frame_err`, no load. A 60-pulse frame → overrun, `frame_err`.
6. **Signal loss:** `dcf_in` held low for 2100 ms mid-frame → `frame_ok` drops when `dur_ms` = 2047. The next marker gives no `flag_load`; the frame after that loads.
